// File: rtl/traffic_light_controller_n.sv
// Purpose: N-phase intersection signal controller with round-robin service, min/max green, yellow, all-red clearance, emergency preempt.
// Latency: a sensor sampled at an edge from IDLE shows green on the following cycle; all outputs decode from registered state.
// Backpressure: none; requests are latched in pending until served, so one-cycle sensor pulses are never dropped.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low
//   sensor         per-phase traffic present
//   preempt        emergency request; preempt_phase selects the target (out-of-range -> phase 0)
//   lights         2 bits per phase at [2i+1:2i]: red=00, yellow=01, green=10
//   active_phase   phase in GREEN or YELLOW, else 0
//   active_valid   high in GREEN or YELLOW
//   preempt_ack    high while preempt holds its target phase on green
module traffic_light_controller_n #(
    parameter int N_PHASES  = 5,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    localparam int PW    = (N_PHASES > 1) ? $clog2(N_PHASES) : 1,
    localparam int MAXT0 = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T,
    localparam int MAXT  = (MAXT0 > ALLRED_T) ? MAXT0 : ALLRED_T,
    localparam int CW    = $clog2(MAXT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_PHASES-1:0]     sensor,
    input  logic                    preempt,
    input  logic [PW-1:0]           preempt_phase,
    output logic [2*N_PHASES-1:0]   lights,
    output logic [PW-1:0]           active_phase,
    output logic                    active_valid,
    output logic                    preempt_ack
);

    if (N_PHASES < 2 || N_PHASES > 16) begin : g_bad_n
        $error("traffic_light_controller_n: N_PHASES must be 2..16");
    end
    if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN) begin : g_bad_green
        $error("traffic_light_controller_n: need 1 <= GREEN_MIN <= GREEN_MAX");
    end
    if (YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_clear
        $error("traffic_light_controller_n: YELLOW_T and ALLRED_T must be >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_GREEN, ST_YELLOW, ST_ALLRED} state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N_PHASES-1:0]    pending_q, pending_d;
    logic [PW-1:0]          rr_q, rr_d;
    logic                   pre_q, pre_d;     // current green was held by preempt: GREEN_MIN counts as met
    logic                   ack_q, ack_d;

    logic [N_PHASES-1:0]    req;
    logic [N_PHASES-1:0]    others;
    logic [PW-1:0]          win;
    logic [PW-1:0]          win_next;
    logic                   win_vld;
    logic [PW-1:0]          pre_tgt;
    logic                   grant;
    logic                   min_ok;
    int                     scan_idx;

    // Widen before comparing so the range check stays meaningful when N_PHASES is a power of two.
    function automatic logic [PW-1:0] clamp_phase(input logic [PW-1:0] v);
        logic [31:0] w;
        w = {{(32-PW){1'b0}}, v};
        if (w < 32'(N_PHASES)) return v;
        return '0;
    endfunction

    assign req     = pending_q | sensor;
    assign pre_tgt = clamp_phase(preempt_phase);

    // Round-robin search from rr upward; scanning offsets high-to-low lets the lowest offset win.
    always_comb begin : arb
        win      = '0;
        win_vld  = 1'b0;
        scan_idx = 0;
        for (int k = N_PHASES - 1; k >= 0; k--) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= N_PHASES) scan_idx = scan_idx - N_PHASES;
            if (req[PW'(scan_idx)]) begin
                win_vld = 1'b1;
                win     = PW'(scan_idx);
            end
        end
        if (int'(win) + 1 >= N_PHASES) win_next = '0;
        else                           win_next = win + PW'(1);
    end

    always_comb begin : fsm
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        pre_d     = pre_q;
        grant     = 1'b0;
        others    = req;
        others[phase_q] = 1'b0;
        min_ok    = (cnt_q >= CW'(GREEN_MIN)) || pre_q;

        // The green phase never latches its own sensor; its bit is already clear from the grant.
        pending_d = pending_q | sensor;
        if (state_q == ST_GREEN) pending_d[phase_q] = pending_q[phase_q];

        unique case (state_q)
            ST_IDLE: begin
                if (preempt || win_vld) grant = 1'b1;
            end
            ST_GREEN: begin
                if (cnt_q < CW'(GREEN_MAX)) cnt_d = cnt_q + CW'(1);
                if (preempt) begin
                    if (phase_q != pre_tgt) begin
                        state_d = ST_YELLOW;
                        cnt_d   = CW'(1);
                        pre_d   = 1'b0;
                    end else begin
                        pre_d   = 1'b1;
                    end
                end else if ((|others) &&
                             ((min_ok && !sensor[phase_q]) || cnt_q >= CW'(GREEN_MAX))) begin
                    state_d = ST_YELLOW;
                    cnt_d   = CW'(1);
                    pre_d   = 1'b0;
                end
            end
            ST_YELLOW: begin
                if (cnt_q >= CW'(YELLOW_T)) begin
                    state_d = ST_ALLRED;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_ALLRED: begin
                if (cnt_q >= CW'(ALLRED_T)) begin
                    if (preempt || win_vld) begin
                        grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Preempt grants bypass the rotation so normal service resumes where it left off.
        if (grant) begin
            state_d = ST_GREEN;
            cnt_d   = CW'(1);
            if (preempt) begin
                phase_d = pre_tgt;
                pre_d   = 1'b1;
            end else begin
                phase_d = win;
                rr_d    = win_next;
                pre_d   = 1'b0;
            end
            pending_d[phase_d] = 1'b0;
        end

        ack_d = (state_d == ST_GREEN) && preempt && (phase_d == pre_tgt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            rr_q      <= '0;
            pre_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            pre_q     <= pre_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin : out_dec
        lights       = '0;
        active_valid = (state_q == ST_GREEN) || (state_q == ST_YELLOW);
        active_phase = active_valid ? phase_q : '0;
        if (state_q == ST_GREEN)  lights[{phase_q, 1'b0} +: 2] = 2'b10;
        if (state_q == ST_YELLOW) lights[{phase_q, 1'b0} +: 2] = 2'b01;
        preempt_ack  = ack_q;
    end

endmodule

// File: doc/traffic_light_controller_n.md
Name: traffic_light_controller_n

Overview:
- Parametrised successor to the fixed five-direction intersection controller. It serves N mutually conflicting phases, and at most one phase is non-red at any time.
- Each phase has one sensor and one 2-bit light. Requests are latched and granted round-robin, with min/max green, yellow and all-red clearance timing.
- Adds emergency preemption to a selectable phase.
- Sits at the top of the intersection datapath and drives light outputs directly.

Parameters:
- N_PHASES, 5, number of phases (2..16)
- GREEN_MIN, 5, minimum green cycles (>=1)
- GREEN_MAX, 10, green cycles after which a phase yields if others wait (>=GREEN_MIN)
- YELLOW_T, 2, yellow cycles (>=1)
- ALLRED_T, 1, all-red clearance cycles (>=1)
- Derived localparams: PW = max(1, $clog2(N_PHASES)); CW wide enough for max(GREEN_MAX, YELLOW_T, ALLRED_T).
- Illegal parameter values are caught by an elaboration-time $error.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- sensor  in  N_PHASES  per-phase traffic present
- preempt  in  1  emergency request
- preempt_phase  in  PW  phase to force green; values >= N_PHASES are treated as 0
- lights  out  2*N_PHASES  phase i at bits [2i+1:2i]; red=2'b00, yellow=2'b01, green=2'b10 (light_package colors encoding)
- active_phase  out  PW  phase currently green or yellow; 0 when none
- active_valid  out  1  1 in GREEN or YELLOW
- preempt_ack  out  1  1 while preempt=1 and preempt_phase is green

Behaviour:
- States: IDLE (all red, nothing pending), GREEN, YELLOW, ALLRED. lights, active_phase, active_valid and preempt_ack decode from registered state only. No combinational path from inputs to outputs.
- Reset (reset=0 at an edge), including mid-operation:
  - state=IDLE, all lights red, active_valid=0, active_phase=0, preempt_ack=0.
  - pending cleared, cnt cleared, round-robin pointer rr=0.
- Request vector: req = pending | sensor.
  - pending[i] sets on any edge where sensor[i]=1, except when phase i is in GREEN.
  - Sensor pulses of one cycle are never lost.
  - pending[p] clears on the edge that enters GREEN for p.
- Arbitration: winner = first i with req[i]=1, searching from rr upward with wrap mod N_PHASES. On each grant, rr <= winner+1 mod N_PHASES. Preempt overrides arbitration (see below).
- IDLE:
  - If req != 0 or preempt, enter GREEN of the winner (or preempt_phase) at that edge, with cnt=1. Light latency is 1 cycle from the sampled sensor.
  - Otherwise stay in IDLE.
- GREEN, phase p:
  - cnt increments each cycle, saturating at GREEN_MAX.
  - others = req with bit p masked; go to YELLOW when others != 0 and ((cnt >= GREEN_MIN and sensor[p]=0) or cnt >= GREEN_MAX).
  - With others = 0, rest on green indefinitely, even after sensor[p] falls.
- YELLOW: lasts exactly YELLOW_T cycles, then ALLRED.
- ALLRED: lasts exactly ALLRED_T cycles. Then enter GREEN of the winner if req != 0 or preempt; otherwise go to IDLE.
  - A phase may be re-granted to itself if it is the only requester.
- Preemption, with q = preempt_phase:
  - In GREEN of p != q with preempt=1: go to YELLOW on the next edge, ignoring GREEN_MIN.
  - YELLOW and ALLRED always run to completion; timings are never shortened.
  - At the next grant point (IDLE or end of ALLRED) with preempt=1: grant q, and leave rr unchanged.
  - In GREEN of q with preempt=1: hold green; the exit rule is suppressed.
  - When preempt falls: treat cnt as >= GREEN_MIN, then apply the normal exit rule.
  - If preempt_phase changes mid-preempt, treat it as a new target.
- Safety invariants, checked every cycle:
  - At most one light is non-red.
  - Never green->red or red->yellow directly.
  - Between any two different non-red phases there are >= ALLRED_T all-red cycles.

Test Plan:
- Defaults, reset=0 for 2 cycles, then sensor=0 -> all lights 2'b00 and active_valid=0 indefinitely; asserting reset=0 while phase 2 is green -> all red after that edge, rr=0.
- Single requester: sensor[1]=1 for 1 cycle from IDLE -> phase 1 green next cycle; it rests on green with no other requests; sensor[3] then pulses for 1 cycle -> phase 1 green for >=5 total cycles, yellow 2, all-red 1, then phase 3 green.
- Fairness: all 5 sensors held at 1 -> grant order 0,1,2,3,4,0; each green lasts exactly 10 cycles, each yellow 2, each all-red 1.
- Extension: sensor[0] held, sensor[2] arrives at green cycle 3 -> phase 0 yellow after green cycle 10; with sensor[0] dropping at green cycle 6 instead -> yellow after green cycle 6.
- Preempt: phase 0 in green cycle 2, preempt=1 with preempt_phase=4 -> yellow next edge, 2 yellow, 1 all-red, phase 4 green, preempt_ack=1; hold 20 cycles -> green held; release with sensor[1]=1 pending -> phase 4 yellow on the next edge; rr unchanged, so phase 1 is served next.
- Parameter sweep N_PHASES=2 and 16, GREEN_MIN=GREEN_MAX=1, YELLOW_T=ALLRED_T=1 -> safety invariants hold under random sensors for 10k cycles.
